// File: rtl/shake_sponge_ctrl.sv
// rtl/shake_sponge_ctrl.sv - SHAKE sponge controller driving an external Keccak-f[1600] core
// Optional feature: define SHAKE_SPONGE_PERF_CNT_EN to add the perm_count output.
module shake_sponge_ctrl #(
  parameter int RATE_WORDS = 21
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [15:0]   out_words,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [63:0]   in_data,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [63:0]   out_data,
  output logic          busy,
  output logic          done,
  output logic          perm_start,
  output logic [1599:0] perm_state_in,
  input  logic          perm_ready,
  input  logic          perm_done,
  input  logic [1599:0] perm_state_out
`ifdef SHAKE_SPONGE_PERF_CNT_EN
  ,
  output logic [15:0]   perm_count
`endif
);

  localparam int IW = $clog2(RATE_WORDS + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(RATE_WORDS - 1);

  typedef enum logic [2:0] {IDLE, ABSORB, PAD, PERM, SQUEEZE} fsm_t;

  fsm_t          fsm_q, fsm_d, ret_q, ret_d;
  logic [1599:0] st_q, st_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [15:0]   rem_q, rem_d;
  logic          issued_q, issued_d;
  logic          done_q, done_d;
  logic [63:0]   lane;
  logic [1599:0] pad_mask;

  assign lane          = st_q[{idx_q, 6'b0} +: 64];
  assign perm_state_in = st_q;
  assign out_data      = out_valid ? lane : 64'd0;
  assign busy          = (fsm_q != IDLE);
  assign done          = done_q;

  // Both pad bits applied as XOR so a shared lane ends up with 0x800000000000001F.
  always_comb begin
    pad_mask = '0;
    pad_mask[{idx_q, 6'b0} +: 64] = 64'h1F;
    pad_mask[64*(RATE_WORDS-1) +: 64] = pad_mask[64*(RATE_WORDS-1) +: 64] ^ 64'h8000_0000_0000_0000;
  end

  always_comb begin
    fsm_d      = fsm_q;
    ret_d      = ret_q;
    st_d       = st_q;
    idx_d      = idx_q;
    rem_d      = rem_q;
    issued_d   = issued_q;
    done_d     = 1'b0;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    perm_start = 1'b0;
    unique case (fsm_q)
      IDLE: begin
        if (start) begin
          fsm_d = ABSORB;
          st_d  = '0;
          idx_d = '0;
          rem_d = out_words;
        end
      end
      ABSORB: begin
        in_ready = 1'b1;
        if (in_valid) begin
          st_d[{idx_q, 6'b0} +: 64] = lane ^ in_data;
          if (idx_q == LAST_IDX) begin
            fsm_d = PERM;
            ret_d = in_last ? PAD : ABSORB;
            idx_d = '0;
          end else begin
            idx_d = idx_q + 1'b1;
            if (in_last) fsm_d = PAD;
          end
        end
      end
      PAD: begin
        st_d  = st_q ^ pad_mask;
        fsm_d = PERM;
        ret_d = SQUEEZE;
      end
      PERM: begin
        perm_start = perm_ready && !issued_q;
        if (perm_start) issued_d = 1'b1;
        // perm_done only counts once our request has been issued
        if (issued_q && perm_done) begin
          st_d     = perm_state_out;
          idx_d    = '0;
          issued_d = 1'b0;
          if (ret_q == SQUEEZE && rem_q == 16'd0) begin
            fsm_d  = IDLE;
            done_d = 1'b1;
          end else begin
            fsm_d = ret_q;
          end
        end
      end
      SQUEEZE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          rem_d = rem_q - 16'd1;
          if (rem_q == 16'd1) begin
            fsm_d  = IDLE;
            done_d = 1'b1;
          end else if (idx_q == LAST_IDX) begin
            fsm_d = PERM;
            ret_d = SQUEEZE;
            idx_d = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q    <= IDLE;
      ret_q    <= IDLE;
      st_q     <= '0;
      idx_q    <= '0;
      rem_q    <= '0;
      issued_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      fsm_q    <= fsm_d;
      ret_q    <= ret_d;
      st_q     <= st_d;
      idx_q    <= idx_d;
      rem_q    <= rem_d;
      issued_q <= issued_d;
      done_q   <= done_d;
    end
  end

`ifdef SHAKE_SPONGE_PERF_CNT_EN
  logic [15:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (fsm_q == IDLE && start) begin
      cnt_q <= '0;
    end else if (perm_start && cnt_q != 16'hFFFF) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign perm_count = cnt_q;
`endif

endmodule

// File: tb/tb_shake_sponge_ctrl.sv
// tb/tb_shake_sponge_ctrl.sv - scoreboard bench for shake_sponge_ctrl with a mock permutation core
`timescale 1ns/1ps
module tb_shake_sponge_ctrl;
  localparam int R = 21;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, start, in_valid, in_ready, in_last, out_valid, out_ready;
  logic [15:0]   out_words;
  logic [63:0]   in_data, out_data;
  logic          busy, done, perm_start, perm_ready, perm_done;
  logic [1599:0] perm_state_in, perm_state_out;
`ifdef SHAKE_SPONGE_PERF_CNT_EN
  logic [15:0]   perm_count;
`endif

  shake_sponge_ctrl #(.RATE_WORDS(R)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .out_words(out_words),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done), .perm_start(perm_start), .perm_state_in(perm_state_in),
    .perm_ready(perm_ready), .perm_done(perm_done), .perm_state_out(perm_state_out)
`ifdef SHAKE_SPONGE_PERF_CNT_EN
    , .perm_count(perm_count)
`endif
  );

  int vectors = 0, miscompares = 0;
  int cyc = 0, n_perm = 0, n_done = 0, n_ovalid = 0, n_oacc = 0, done_cyc = -1, pd_cyc = -1;
  logic tog = 1'b0;
  logic [63:0]   exp_out[$];
  logic [1599:0] exp_perm[$];
  logic [1599:0] perm_log[$];
  int            perm_out_mark[$];
  logic [63:0]   m1[$], m2[$], m3[$], m4[$], m5[$], m6[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic fail_msg(input string name);
    vectors++; miscompares++;
    $display("FAIL %s: bound expired or unexpected event", name);
  endtask

  task automatic checkint(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkst(input string name, input logic [1599:0] act, input logic [1599:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      for (int i = 0; i < 25; i++)
        if (act[64*i +: 64] !== exp[64*i +: 64]) begin
          $display("FAIL %s lane %0d: got %h expected %h", name, i, act[64*i +: 64], exp[64*i +: 64]);
          break;
        end
    end
  endtask

  // Stand-in for Keccak-f[1600]: the controller never looks inside the permutation.
  function automatic logic [1599:0] mock_perm(input logic [1599:0] s);
    logic [1599:0] o;
    logic [63:0] l;
    o = '0;
    for (int i = 0; i < 25; i++) begin
      l = s[64*((i+1)%25) +: 64];
      o[64*i +: 64] = {l[62:0], l[63]} ^ (64'(i+1) * 64'h9E37_79B9_7F4A_7C15);
    end
    return o;
  endfunction

  task automatic model_job(input logic [63:0] msg[$], input int nw);
    logic [1599:0] s;
    int pos;
    s = '0; pos = 0;
    foreach (msg[i]) begin
      s[64*pos +: 64] ^= msg[i];
      pos++;
      if (pos == R) begin exp_perm.push_back(s); s = mock_perm(s); pos = 0; end
    end
    s[64*pos +: 64] ^= 64'h1F;
    s[64*(R-1) +: 64] ^= 64'h8000_0000_0000_0000;
    exp_perm.push_back(s); s = mock_perm(s);
    for (int k = 0; k < nw; k++) begin
      if (k > 0 && k % R == 0) begin exp_perm.push_back(s); s = mock_perm(s); end
      exp_out.push_back(s[64*(k%R) +: 64]);
    end
  endtask

  initial begin : responder
    int cnt;
    logic prev_ps;
    logic [1599:0] cap;
    cnt = -1; prev_ps = 1'b0; cap = '0;
    perm_done = 1'b0; perm_state_out = '0; perm_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (perm_done) perm_done = 1'b0;
      if (perm_start) begin
        checkint("perm_start_width", prev_ps, 0);
        n_perm++;
        perm_log.push_back(perm_state_in);
        perm_out_mark.push_back(n_oacc);
        if (exp_perm.size() == 0) fail_msg("perm_unexpected");
        else checkst("perm_in", perm_state_in, exp_perm.pop_front());
        cap = perm_state_in; cnt = 6;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          perm_done = 1'b1; perm_state_out = mock_perm(cap); pd_cyc = cyc; cnt = -1;
        end
      end
      prev_ps = perm_start;
    end
  end

  initial begin : out_mon
    logic held_v;
    logic [63:0] held_d;
    held_v = 1'b0; held_d = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin held_v = 1'b0; continue; end
      if (out_valid) n_ovalid++;
      if (held_v) check64("out_hold", out_data, held_d);
      if (out_valid && out_ready) begin
        n_oacc++;
        if (exp_out.size() == 0) fail_msg("out_unexpected");
        else check64("out_data", out_data, exp_out.pop_front());
      end
      held_v = out_valid && !out_ready;
      held_d = out_data;
    end
  end

  initial begin : done_mon
    forever begin
      @(negedge clk);
      if (done) begin n_done++; done_cyc = cyc; end
    end
  end

  initial begin : out_ready_drv
    forever begin
      @(posedge clk); #1;
      out_ready = tog ? ~out_ready : 1'b1;
    end
  end

  task automatic do_start(input logic [15:0] nw);
    @(posedge clk); #1; start = 1'b1; out_words = nw;
    @(posedge clk); #1; start = 1'b0;
  endtask

  task automatic send_msg(input logic [63:0] msg[$]);
    int t;
    foreach (msg[i]) begin
      in_valid = 1'b1; in_data = msg[i]; in_last = (i == msg.size() - 1);
      t = 0;
      forever begin
        @(negedge clk);
        if (in_ready) break;
        if (++t > 2000) begin fail_msg("in_ready_timeout"); break; end
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_last = 1'b0; in_data = '0;
  endtask

  task automatic end_job(input int target, input string tag);
    int t;
    t = 0;
    while (n_done < target && t < 3000) begin @(negedge clk); t++; end
    if (t >= 3000) fail_msg({tag, " done_timeout"});
    repeat (4) @(negedge clk);
    checkint({tag, " done_count"}, n_done, target);
    checkint({tag, " out_left"}, exp_out.size(), 0);
    checkint({tag, " perm_left"}, exp_perm.size(), 0);
    checkint({tag, " busy_end"}, busy, 0);
  endtask

  initial begin : stim
    int base, t, ndone;
    logic [1599:0] e;
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int base, t, ndone, base_ov;
    logic [1599:0] e;
    rst_n = 1'b0; start = 1'b0; out_words = '0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    out_ready = 1'b1;
    m1.push_back(64'h0);
    for (int i = 0; i < 21; i++) m2.push_back(64'h1000_0000_0000_0000 + 64'(i));
    for (int i = 0; i < 20; i++) m3.push_back(64'hA000_0000_0000_0000 | 64'(i + 1));
    m4.push_back(64'h55);
    m5.push_back(64'hDEAD_BEEF_CAFE_F00D);
    m6.push_back(64'h7);

    repeat (3) @(negedge clk);
    checkint("rst busy", busy, 0);
    checkint("rst in_ready", in_ready, 0);
    checkint("rst out_valid", out_valid, 0);
    checkint("rst perm_start", perm_start, 0);
    checkint("rst done", done, 0);
    check64("rst out_data", out_data, 64'h0);
    checkst("rst state", perm_state_in, '0);
    @(posedge clk); #1; rst_n = 1'b1;

    // single zero lane, four output lanes
    ndone = 1; base = n_perm; perm_log.delete();
    model_job(m1, 4); do_start(16'd4); send_msg(m1); end_job(ndone, "t1");
    checkint("t1 perm_count", n_perm - base, 1);
    e = '0; e[64 +: 64] = 64'h1F; e[64*20 +: 64] = 64'h8000_0000_0000_0000;
    checkst("t1 pad_state", perm_log[0], e);

    // full-rate message: absorb permutation then padding-only block
    ndone++; base = n_perm; perm_log.delete();
    model_job(m2, 4); do_start(16'd4); send_msg(m2);
    t = 0;
    while (!out_valid && t < 2000) begin @(negedge clk); t++; end
    if (t >= 2000) fail_msg("t2 out_valid_timeout");
    checkint("t2 perms_before_out", n_perm - base, 2);
    end_job(ndone, "t2");
    e = '0; e[63:0] = 64'h1F; e[64*20 +: 64] = 64'h8000_0000_0000_0000;
    checkst("t2 pad_only_block", perm_log[1] ^ mock_perm(perm_log[0]), e);

    // 20 lanes: both pad bits land in lane 20
    ndone++; base = n_perm; perm_log.delete();
    model_job(m3, 3); do_start(16'd3); send_msg(m3); end_job(ndone, "t3");
    checkint("t3 perm_count", n_perm - base, 1);
    check64("t3 lane20", perm_log[0][64*20 +: 64], 64'h8000_0000_0000_001F);
    check64("t3 lane19", perm_log[0][64*19 +: 64], 64'hA000_0000_0000_0014);

    // 22 outputs with back-pressure: third permutation after 21 output lanes
    ndone++; base = n_perm; perm_log.delete(); perm_out_mark.delete();
    tog = 1'b1; t = n_oacc;
    model_job(m2, 22); do_start(16'd22); send_msg(m2); end_job(ndone, "t4");
    tog = 1'b0;
    checkint("t4 perm_count", n_perm - base, 3);
    checkint("t4 lanes_out", n_oacc - t, 22);
    checkint("t4 third_perm_after", perm_out_mark[2] - t, 21);

    // reset while the permutation is outstanding
    base = n_perm;
    model_job(m4, 2); do_start(16'd2); send_msg(m4);
    t = 0;
    while (n_perm == base && t < 2000) begin @(negedge clk); t++; end
    if (t >= 2000) fail_msg("t5 perm_timeout");
    @(posedge clk); #2; rst_n = 1'b0; #1;
    checkint("t5 busy", busy, 0);
    checkint("t5 perm_start", perm_start, 0);
    checkint("t5 in_ready", in_ready, 0);
    checkint("t5 out_valid", out_valid, 0);
    check64("t5 out_data", out_data, 64'h0);
    checkst("t5 state", perm_state_in, '0);
    exp_out.delete(); exp_perm.delete();
    repeat (2) @(posedge clk); #1; rst_n = 1'b1;
    repeat (12) @(negedge clk);
    checkint("t5 no_done", n_done, ndone);
    checkint("t5 idle_after_late_done", busy, 0);

    ndone++;
    model_job(m5, 2); do_start(16'd2); send_msg(m5); end_job(ndone, "t6");

    // out_words=0 with a stray start while busy
    ndone++; base = n_perm; base_ov = n_ovalid;
    model_job(m6, 0); do_start(16'd0); send_msg(m6); do_start(16'd5); end_job(ndone, "t7");
    checkint("t7 perm_count", n_perm - base, 1);
    checkint("t7 no_out_valid", n_ovalid - base_ov, 0);
    checkint("t7 done_after_capture", done_cyc, pd_cyc + 1);
`ifdef SHAKE_SPONGE_PERF_CNT_EN
    checkint("t7 perm_count_port", perm_count, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
